// File: rtl/uart_apb_pkg.sv
// Shared constants for the APB-to-UART FIFO bridge: register map,
// STATUS/CTRL bit positions and the bridge FSM encoding.
package uart_apb_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_TXCNT  = 2'd3;

    localparam int ST_RX_EMPTY     = 0;
    localparam int ST_TX_FULL      = 1;
    localparam int ST_BUSY         = 2;
    localparam int ST_TX_TIMEOUT   = 3;
    localparam int ST_RX_UNDERFLOW = 4;

    localparam int CTRL_RX_IE  = 0;
    localparam int CTRL_ERR_IE = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        WAIT_TX = 2'd2,
        RESP    = 2'd3
    } state_t;

endpackage

// File: rtl/uart_apb_txwait.sv
// Stall timer for DATA writes blocked on a full TX FIFO.
// TX_TIMEOUT=0 removes the counter and never expires.
module uart_apb_txwait #(
    parameter int TX_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    generate
        if (TX_TIMEOUT == 0) begin : g_off
            logic unused_in;
            assign unused_in = ^{clk, rst_n, clr, en};
            assign expired   = 1'b0;
        end else begin : g_on
            localparam int W = $clog2(TX_TIMEOUT + 1);
            localparam logic [W-1:0] LAST = W'(TX_TIMEOUT - 1);

            logic [W-1:0] cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (clr) begin
                    cnt <= '0;
                end else if (en) begin
                    cnt <= cnt + W'(1);
                end
            end

            assign expired = (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/uart_apb_ctrl.sv
// APB3 responder driving the UART FIFO byte interface.
// Define UART_APB_TXCNT_EN to add the TXCNT transmit counter at index 3.
module uart_apb_ctrl
    import uart_apb_pkg::*;
#(
    parameter int BUS_WIDTH  = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int TX_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [BUS_WIDTH-1:0]  PWDATA,
    output logic [BUS_WIDTH-1:0]  PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [7:0]            tx_byte,
    output logic                  transmit,
    input  logic                  tx_fifo_full,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_fifo_empty,
    output logic                  rx_fifo_pop,
    input  logic                  uart_busy,
    output logic                  irq
);

    state_t state, state_n;

    logic [1:0] idx_q;
    logic       wr_q;
    logic [7:0] wdata_q;
    logic       latch;

    logic [1:0] ctrl_q, ctrl_n;
    logic       tt_q, ru_q, tt_set, ru_set;
    logic [1:0] w1c;
    logic [4:0] status;

    logic [BUS_WIDTH-1:0] prdata_n;
    logic       pready_n, pslverr_n, transmit_n, pop_n;
    logic [7:0] txbyte_n;
    logic       tmr_clr, tmr_en, tmr_exp;

`ifdef UART_APB_TXCNT_EN
    logic [15:0] txcnt_q;
    logic        txcnt_clr;
`endif

    logic unused_bits;
    assign unused_bits = ^{PADDR, PWDATA};

    assign status = {ru_q, tt_q, uart_busy, tx_fifo_full, rx_fifo_empty};

    uart_apb_txwait #(.TX_TIMEOUT(TX_TIMEOUT)) u_txwait (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_exp)
    );

    always_comb begin
        state_n    = state;
        prdata_n   = PRDATA;
        pslverr_n  = PSLVERR;
        pready_n   = 1'b0;
        transmit_n = 1'b0;
        pop_n      = 1'b0;
        txbyte_n   = tx_byte;
        ctrl_n     = ctrl_q;
        tt_set     = 1'b0;
        ru_set     = 1'b0;
        w1c        = 2'b00;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        latch      = 1'b0;
`ifdef UART_APB_TXCNT_EN
        txcnt_clr  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                prdata_n  = '0;
                pslverr_n = 1'b0;
                if (PSEL && PENABLE) begin
                    latch   = 1'b1;
                    state_n = EXEC;
                end
            end
            // A dropped PSEL still completes the access, only PREADY is withheld.
            EXEC: begin
                state_n   = RESP;
                pready_n  = PSEL;
                prdata_n  = '0;
                pslverr_n = 1'b0;
                unique case (idx_q)
                    REG_DATA: begin
                        if (wr_q) begin
                            if (tx_fifo_full) begin
                                state_n  = WAIT_TX;
                                pready_n = 1'b0;
                                tmr_clr  = 1'b1;
                            end else begin
                                transmit_n = 1'b1;
                                txbyte_n   = wdata_q;
                            end
                        end else if (rx_fifo_empty) begin
                            pslverr_n = 1'b1;
                            ru_set    = 1'b1;
                        end else begin
                            prdata_n = BUS_WIDTH'(rx_byte);
                            pop_n    = 1'b1;
                        end
                    end
                    REG_STATUS: begin
                        if (wr_q) w1c = wdata_q[ST_RX_UNDERFLOW:ST_TX_TIMEOUT];
                        else      prdata_n = BUS_WIDTH'(status);
                    end
                    REG_CTRL: begin
                        if (wr_q) ctrl_n = wdata_q[1:0];
                        else      prdata_n = BUS_WIDTH'(ctrl_q);
                    end
                    REG_TXCNT: begin
`ifdef UART_APB_TXCNT_EN
                        if (wr_q) txcnt_clr = 1'b1;
                        else      prdata_n = BUS_WIDTH'(txcnt_q);
`endif
                    end
                endcase
            end
            WAIT_TX: begin
                if (!tx_fifo_full) begin
                    state_n    = RESP;
                    pready_n   = PSEL;
                    transmit_n = 1'b1;
                    txbyte_n   = wdata_q;
                end else if (tmr_exp) begin
                    state_n   = RESP;
                    pready_n  = PSEL;
                    pslverr_n = 1'b1;
                    tt_set    = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            RESP: begin
                state_n   = IDLE;
                prdata_n  = '0;
                pslverr_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= REG_DATA;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else if (latch) begin
            idx_q   <= PADDR[3:2];
            wr_q    <= PWRITE;
            wdata_q <= PWDATA[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PRDATA      <= '0;
            PREADY      <= 1'b0;
            PSLVERR     <= 1'b0;
            transmit    <= 1'b0;
            rx_fifo_pop <= 1'b0;
            tx_byte     <= '0;
            ctrl_q      <= '0;
            tt_q        <= 1'b0;
            ru_q        <= 1'b0;
            irq         <= 1'b0;
        end else begin
            PRDATA      <= prdata_n;
            PREADY      <= pready_n;
            PSLVERR     <= pslverr_n;
            transmit    <= transmit_n;
            rx_fifo_pop <= pop_n;
            tx_byte     <= txbyte_n;
            ctrl_q      <= ctrl_n;
            tt_q        <= tt_set | (tt_q & ~w1c[0]);
            ru_q        <= ru_set | (ru_q & ~w1c[1]);
            irq         <= (ctrl_q[CTRL_RX_IE] & ~rx_fifo_empty)
                         | (ctrl_q[CTRL_ERR_IE] & (tt_q | ru_q));
        end
    end

`ifdef UART_APB_TXCNT_EN
    // Clear wins over a coincident push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         txcnt_q <= '0;
        else if (txcnt_clr) txcnt_q <= '0;
        else if (transmit)  txcnt_q <= txcnt_q + 16'd1;
    end
`endif

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Self-checking bench for uart_apb_ctrl: directed vector table,
// hand-written corner sequences and random traffic against a model.
module tb_uart_apb_ctrl;

    localparam int BW  = 16;
    localparam int AW  = 4;
    localparam int TXT = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [AW-1:0] PADDR = '0;
    logic [BW-1:0] PWDATA = '0;
    logic [BW-1:0] PRDATA;
    logic          PREADY, PSLVERR;
    logic [7:0]    tx_byte;
    logic          transmit;
    logic          tx_fifo_full = 1'b0;
    logic [7:0]    rx_byte = '0;
    logic          rx_fifo_empty = 1'b1;
    logic          rx_fifo_pop;
    logic          uart_busy = 1'b0;
    logic          irq;

    uart_apb_ctrl #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .TX_TIMEOUT(TXT)) dut (
        .clk(clk), .rst_n(rst_n),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR),
        .tx_byte(tx_byte), .transmit(transmit),
        .tx_fifo_full(tx_fifo_full), .rx_byte(rx_byte),
        .rx_fifo_empty(rx_fifo_empty), .rx_fifo_pop(rx_fifo_pop),
        .uart_busy(uart_busy), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // One APB transfer. rel>0 holds tx_fifo_full high until `rel`
    // samples into the access phase; the bound of 40 samples ends a hung transfer.
    task automatic apb(input bit wr, input logic [1:0] idx,
                       input logic [15:0] wd, input int rel,
                       output logic [15:0] rd, output bit err,
                       output int lat, output int ntx, output int npop,
                       output logic [7:0] txb);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
        PADDR = {idx, 2'b00}; PWDATA = wd;
        if (rel > 0) tx_fifo_full = 1'b1;
        @(negedge clk);
        PENABLE = 1'b1;
        lat = 0; ntx = 0; npop = 0; rd = '0; err = 1'b0; txb = '0;
        forever begin
            @(negedge clk);
            lat++;
            if (transmit) begin ntx++; txb = tx_byte; end
            if (rx_fifo_pop) npop++;
            if (PREADY) begin rd = PRDATA; err = PSLVERR; break; end
            if (lat == rel) tx_fifo_full = 1'b0;
            if (lat >= 40) break;
        end
        PSEL = 1'b0; PENABLE = 1'b0; tx_fifo_full = 1'b0;
        @(negedge clk);
        if (transmit) ntx++;
        if (rx_fifo_pop) npop++;
    endtask

    typedef struct {
        bit         wr;
        logic [1:0] idx;
        logic [15:0] wd;
        bit         empty;
        bit         busy;
        logic [7:0] rxb;
        int         rel;
        logic [15:0] rd;
        bit         err;
        int         lat;
        int         ntx;
        int         npop;
        logic [7:0] txb;
    } vec_t;

    vec_t vt[16];

    logic [15:0] rd;
    bit          err;
    int          lat, ntx, npop;
    logic [7:0]  txb;

    logic [1:0]  m_ctrl;
    bit          m_tt, m_ru;
    int          m_cnt;

    initial begin
        //           wr idx  wd       emp bsy rxb   rel rd       err lat ntx pop txb
        vt[0]  = '{1, 2'd0, 16'h0041, 1, 0, 8'h00, 0,  16'h0000, 0, 2,  1, 0, 8'h41};
        vt[1]  = '{0, 2'd0, 16'h0000, 0, 0, 8'h5A, 0,  16'h005A, 0, 2,  0, 1, 8'h00};
        vt[2]  = '{0, 2'd0, 16'h0000, 1, 0, 8'hA5, 0,  16'h0000, 1, 2,  0, 0, 8'h00};
        vt[3]  = '{0, 2'd1, 16'h0000, 1, 0, 8'h00, 0,  16'h0011, 0, 2,  0, 0, 8'h00};
        vt[4]  = '{1, 2'd1, 16'h0010, 1, 0, 8'h00, 0,  16'h0000, 0, 2,  0, 0, 8'h00};
        vt[5]  = '{0, 2'd1, 16'h0000, 1, 0, 8'h00, 0,  16'h0001, 0, 2,  0, 0, 8'h00};
        vt[6]  = '{1, 2'd0, 16'h00C3, 1, 0, 8'h00, 99, 16'h0000, 1, 10, 0, 0, 8'h00};
        vt[7]  = '{0, 2'd1, 16'h0000, 1, 0, 8'h00, 0,  16'h0009, 0, 2,  0, 0, 8'h00};
        vt[8]  = '{1, 2'd0, 16'h1234, 1, 0, 8'h00, 4,  16'h0000, 0, 5,  1, 0, 8'h34};
        vt[9]  = '{1, 2'd1, 16'hFFFF, 1, 0, 8'h00, 0,  16'h0000, 0, 2,  0, 0, 8'h00};
        vt[10] = '{0, 2'd1, 16'h0000, 0, 0, 8'h00, 0,  16'h0000, 0, 2,  0, 0, 8'h00};
        vt[11] = '{0, 2'd1, 16'h0000, 1, 1, 8'h00, 0,  16'h0005, 0, 2,  0, 0, 8'h00};
        vt[12] = '{1, 2'd2, 16'hFFFE, 1, 0, 8'h00, 0,  16'h0000, 0, 2,  0, 0, 8'h00};
        vt[13] = '{0, 2'd2, 16'h0000, 1, 0, 8'h00, 0,  16'h0002, 0, 2,  0, 0, 8'h00};
`ifdef UART_APB_TXCNT_EN
        vt[14] = '{0, 2'd3, 16'h0000, 1, 0, 8'h00, 0,  16'h0002, 0, 2,  0, 0, 8'h00};
`else
        vt[14] = '{0, 2'd3, 16'h0000, 1, 0, 8'h00, 0,  16'h0000, 0, 2,  0, 0, 8'h00};
`endif
        vt[15] = '{1, 2'd2, 16'h0000, 1, 0, 8'h00, 0,  16'h0000, 0, 2,  0, 0, 8'h00};

        repeat (3) @(negedge clk);
        check("rst_pready", PREADY, 0);
        check("rst_pslverr", PSLVERR, 0);
        check("rst_prdata", PRDATA, 0);
        check("rst_transmit", transmit, 0);
        check("rst_pop", rx_fifo_pop, 0);
        check("rst_irq", irq, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            rx_fifo_empty = vt[i].empty;
            uart_busy     = vt[i].busy;
            rx_byte       = vt[i].rxb;
            apb(vt[i].wr, vt[i].idx, vt[i].wd, vt[i].rel,
                rd, err, lat, ntx, npop, txb);
            check($sformatf("v%0d_prdata", i), rd, vt[i].rd);
            check($sformatf("v%0d_pslverr", i), err, vt[i].err);
            check($sformatf("v%0d_latency", i), lat, vt[i].lat);
            check($sformatf("v%0d_transmits", i), ntx, vt[i].ntx);
            check($sformatf("v%0d_pops", i), npop, vt[i].npop);
            if (vt[i].ntx == 1)
                check($sformatf("v%0d_tx_byte", i), txb, vt[i].txb);
        end
        uart_busy = 1'b0;

        // PSEL dropped during EXEC: push still happens, no PREADY.
        @(negedge clk);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = '0; PWDATA = 16'h0077;
        @(negedge clk);
        PENABLE = 1'b1;
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge clk);
        check("drop_transmit", transmit, 1);
        check("drop_tx_byte", tx_byte, 8'h77);
        check("drop_pready", PREADY, 0);
        @(negedge clk);
        check("drop_single_pulse", transmit, 0);

        // rx interrupt follows rx_fifo_empty and CTRL one cycle later.
        rx_fifo_empty = 1'b1;
        apb(1, 2'd2, 16'h0001, 0, rd, err, lat, ntx, npop, txb);
        @(negedge clk);
        check("irq_idle_empty", irq, 0);
        rx_fifo_empty = 1'b0;
        @(negedge clk);
        check("irq_rx_ready", irq, 1);
        apb(1, 2'd2, 16'h0000, 0, rd, err, lat, ntx, npop, txb);
        check("irq_disabled", irq, 0);

        // Reset while stalled in WAIT_TX.
        apb(1, 2'd2, 16'h0003, 0, rd, err, lat, ntx, npop, txb);
        @(negedge clk);
        check("irq_before_reset", irq, 1);
        tx_fifo_full = 1'b1;
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = '0; PWDATA = 16'h00EE;
        @(negedge clk);
        PENABLE = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_pready", PREADY, 0);
        check("mrst_pslverr", PSLVERR, 0);
        check("mrst_prdata", PRDATA, 0);
        check("mrst_transmit", transmit, 0);
        check("mrst_pop", rx_fifo_pop, 0);
        check("mrst_irq", irq, 0);
        check("mrst_tx_byte", tx_byte, 0);
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0; tx_fifo_full = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_no_late_push", transmit, 0);
        apb(0, 2'd2, 16'h0000, 0, rd, err, lat, ntx, npop, txb);
        check("mrst_ctrl_cleared", rd, 0);

        // Random traffic against a register-level model.
        m_ctrl = '0; m_tt = 0; m_ru = 0; m_cnt = 0;
        for (int i = 0; i < 150; i++) begin
            bit          wr;
            logic [1:0]  idx;
            logic [15:0] wd, e_rd;
            bit          e_err;
            int          rel, e_lat, e_ntx, e_npop;
            wr  = 1'($urandom);
            idx = 2'($urandom);
            wd  = 16'($urandom);
            rel = 0;
            if (idx == 2'd0 && wr && $urandom_range(0, 2) == 0)
                rel = $urandom_range(1, 12);
            rx_fifo_empty = 1'($urandom);
            uart_busy     = 1'($urandom);
            rx_byte       = 8'($urandom);
            e_rd = '0; e_err = 0; e_lat = 2; e_ntx = 0; e_npop = 0;
            case (idx)
                2'd0: begin
                    if (wr) begin
                        if (rel > 9) begin
                            e_lat = 2 + TXT; e_err = 1; m_tt = 1;
                        end else begin
                            e_lat = (rel > 1) ? rel + 1 : 2;
                            e_ntx = 1;
                            m_cnt = (m_cnt + 1) % 65536;
                        end
                    end else if (rx_fifo_empty) begin
                        e_err = 1; m_ru = 1;
                    end else begin
                        e_rd = {8'h00, rx_byte}; e_npop = 1;
                    end
                end
                2'd1: begin
                    if (wr) begin
                        if (wd[3]) m_tt = 0;
                        if (wd[4]) m_ru = 0;
                    end else begin
                        e_rd = {11'd0, m_ru, m_tt, uart_busy, 1'b0, rx_fifo_empty};
                    end
                end
                2'd2: begin
                    if (wr) m_ctrl = wd[1:0];
                    else    e_rd = {14'd0, m_ctrl};
                end
                default: begin
`ifdef UART_APB_TXCNT_EN
                    if (wr) m_cnt = 0;
                    else    e_rd = 16'(m_cnt);
`endif
                end
            endcase
            apb(wr, idx, wd, rel, rd, err, lat, ntx, npop, txb);
            check($sformatf("r%0d_prdata", i), rd, e_rd);
            check($sformatf("r%0d_pslverr", i), err, e_err);
            check($sformatf("r%0d_latency", i), lat, e_lat);
            check($sformatf("r%0d_transmits", i), ntx, e_ntx);
            check($sformatf("r%0d_pops", i), npop, e_npop);
            if (e_ntx == 1)
                check($sformatf("r%0d_tx_byte", i), txb, wd[7:0]);
            check($sformatf("r%0d_irq", i), irq,
                  (m_ctrl[0] & ~rx_fifo_empty) | (m_ctrl[1] & (m_tt | m_ru)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_apb_ctrl.md
Name: uart_apb_ctrl

Overview:
- APB3 responder that lets the CPU drive the FIFO-buffered UART's byte interface.
- CPU writes to DATA become single-cycle `transmit` pushes into the UART TX FIFO. CPU reads of DATA capture `rx_byte` and pulse `rx_fifo_pop`.
- Also provides status, interrupt-enable and sticky error registers, and one level interrupt.
- Sits between the APB interconnect and the UART FIFO wrapper.

Parameters:
- BUS_WIDTH, 16, APB PWDATA/PRDATA width; bytes occupy bits [7:0], upper bits write-ignored and read 0.
- ADDR_WIDTH, 4, PADDR width; register select is PADDR[3:2].
- TX_TIMEOUT, 1024, cycles a DATA write may wait on a full TX FIFO before error; 0 means wait forever.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  1 = write
- PADDR  in  ADDR_WIDTH  byte address
- PWDATA  in  BUS_WIDTH  write data
- PRDATA  out  BUS_WIDTH  read data, valid while PREADY=1
- PREADY  out  1  transfer complete
- PSLVERR  out  1  transfer error, valid while PREADY=1
- tx_byte  out  8  byte to UART TX FIFO
- transmit  out  1  one-cycle push into TX FIFO
- tx_fifo_full  in  1  UART TX FIFO full
- rx_byte  in  8  head of UART RX FIFO (first-word-fall-through)
- rx_fifo_empty  in  1  UART RX FIFO empty
- rx_fifo_pop  out  1  one-cycle pop of RX FIFO
- uart_busy  in  1  UART receiving or transmitting
- irq  out  1  level interrupt to CPU

Behaviour:
- Reset: async on rst_n low. All outputs are 0, state is IDLE, CTRL=0, sticky flags=0, timer=0, TXCNT=0.
- Register map (PADDR[3:2]):
  - 0 DATA: write pushes a byte; read pops a byte.
  - 1 STATUS: read-only status bits and W1C sticky flags.
    - [0] rx_fifo_empty
    - [1] tx_fifo_full
    - [2] uart_busy
    - [3] tx_timeout sticky, W1C
    - [4] rx_underflow sticky, W1C
  - 2 CTRL: read/write.
    - [0] rx_ie
    - [1] err_ie
  - 3 TXCNT: see Optional Feature.
- All outputs are registered. The FSM has four states: IDLE, EXEC, WAIT_TX, RESP.
  - IDLE: on PSEL&PENABLE, latch PADDR, PWRITE, PWDATA and go to EXEC.
  - EXEC (1 cycle):
    - DATA write, tx_fifo_full=0: go to RESP with transmit=1 and tx_byte=PWDATA[7:0].
    - DATA write, tx_fifo_full=1: go to WAIT_TX and clear the timer.
    - DATA read, rx_fifo_empty=0: PRDATA<={0,rx_byte}, rx_fifo_pop=1, go to RESP.
    - DATA read, rx_fifo_empty=1: PRDATA=0, PSLVERR=1, set rx_underflow, go to RESP.
    - Any other access: perform the register read/write and go to RESP.
  - WAIT_TX:
    - Each cycle, if tx_fifo_full=0, go to RESP with transmit pulse.
    - Otherwise increment the timer. When timer==TX_TIMEOUT-1 (and TX_TIMEOUT≠0), go to RESP with PSLVERR=1, no transmit, and set tx_timeout.
  - RESP: PREADY=1 for exactly one cycle, then IDLE. transmit and rx_fifo_pop are high only in this cycle. PRDATA and PSLVERR are held through RESP and zeroed in IDLE.
- Latency:
  - PENABLE first seen high at cycle T gives PREADY at T+2; one wait state minimum.
  - A full-FIFO write adds one cycle per stalled cycle.
- Protocol errors:
  - PSEL dropped while in EXEC or WAIT_TX: finish the transaction internally (push/pop still occur) and return to IDLE without PREADY.
  - Reset mid-transfer: abort immediately; no transmit or pop pulse.
- Sticky flags: if a W1C clear and a set happen in the same cycle, the set wins.
- irq is registered: irq <= (rx_ie & !rx_fifo_empty) | (err_ie & (tx_timeout|rx_underflow)).
- Never more than one transmit or rx_fifo_pop pulse per APB transfer.

Optional Feature:
- Macro: UART_APB_TXCNT_EN.
- Defined: TXCNT register at index 3, a 16-bit count of successful transmit pulses.
  - Wraps 0xFFFF→0.
  - Any write clears it; if the clear coincides with a transmit, the result is 0.
  - Read returns the count, zero-extended or truncated to BUS_WIDTH.
- Undefined: index 3 reads 0, writes are ignored, PSLVERR=0, and no counter flops are present.

Decomposition:
- Package uart_apb_pkg holds:
  - register index constants REG_DATA=0, REG_STATUS=1, REG_CTRL=2, REG_TXCNT=3
  - STATUS/CTRL bit positions
  - FSM state encoding (2-bit: IDLE=0, EXEC=1, WAIT_TX=2, RESP=3)
- Sub-module uart_apb_txwait: the timeout counter with clear/enable/expire. Its width is $clog2(TX_TIMEOUT+1), and it always reports not-expired when TX_TIMEOUT=0.

Test Plan:
- Write DATA 0x0041 with TX FIFO not full → one transmit pulse with tx_byte=0x41, PREADY at T+2, PSLVERR=0.
- rx_byte=0x5A, rx_fifo_empty=0, read DATA → PRDATA=0x005A with PREADY, one rx_fifo_pop pulse in the same cycle.
- Read DATA with rx_fifo_empty=1 → PRDATA=0, PSLVERR=1, no pop; STATUS reads 0x0011. Write STATUS 0x0010 → STATUS reads 0x0001.
- TX_TIMEOUT=8, tx_fifo_full held 1, write DATA → PREADY after 8 WAIT_TX cycles, PSLVERR=1, no transmit, STATUS[3]=1.
  - Repeat with full released after 3 cycles → transmit plus PREADY, PSLVERR=0.
- CTRL=0x1, rx_fifo_empty falls → irq=1 the next cycle. CTRL=0 → irq=0 the next cycle.
- Assert rst_n=0 during WAIT_TX → all outputs 0 immediately. After release, an APB read of CTRL returns 0.
